// File: rtl/sccb_write_master.sv
// sccb_write_master
//   Serialises one 32-bit SCCB write frame (device address, 16-bit register
//   address, data byte) onto SCL/SDA for the OV5640 camera. Completion and
//   acknowledge status are reported through a four-phase start/tr_end
//   handshake, so a requester on a slower derived clock can use it safely.
//
// Ports
//   clk_25M   in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   i2c_data  in   [31:24] device addr, [23:8] register addr, [7:0] data
//   start     in   request level, held high until tr_end = 1
//   busy      out  high from frame accept until STOP has completed
//   tr_end    out  done level, cleared the cycle after start is seen low
//   ack       out  1 = every byte of the last frame was ACKed
//   i2c_sclk  out  SCL, push-pull
//   i2c_sdat  inout SDA, open-drain (drives 0 or releases)
//
// Each bit slot is four quarter-bit phases q0..q3 of CLK_DIV cycles each.
// Line levels are registered from the current state/phase, so the bus
// lags the internal state by one cycle; every transition lags equally.
module sccb_write_master #(
    parameter int CLK_DIV = 312
) (
    input  logic        clk_25M,
    input  logic        rst,
    input  logic [31:0] i2c_data,
    input  logic        start,
    output logic        busy,
    output logic        tr_end,
    output logic        ack,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACKS,
        STOP,
        DONE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       phase;
    logic [31:0]      shift_reg;
    logic [2:0]       bit_cnt;
    logic [1:0]       byte_cnt;
    logic             nack;
    logic             sda_low;
    logic             sda_p0;
    logic             sda_p1;
    logic             tick;
    logic             slot_end;

    assign tick     = (div_cnt == DIV_LAST);
    assign slot_end = tick && (phase == 2'd3);

    // Open-drain: only ever pull low, otherwise release to the pull-up.
    assign i2c_sdat = sda_low ? 1'b0 : 1'bz;

    // SDA input synchroniser, stage p0 -> p1
    always_ff @(posedge clk_25M) begin
        sda_p0 <= i2c_sdat;
        sda_p1 <= sda_p0;
    end

    always_ff @(posedge clk_25M) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            phase    <= '0;
            busy     <= 1'b0;
            tr_end   <= 1'b0;
            ack      <= 1'b0;
            nack     <= 1'b0;
            bit_cnt  <= 3'd7;
            byte_cnt <= 2'd0;
            i2c_sclk <= 1'b1;
            sda_low  <= 1'b0;
        end else begin
            // Bus levels for the phase currently in progress.
            case (state)
                START: begin
                    i2c_sclk <= (phase < 2'd2);
                    sda_low  <= (phase != 2'd0);
                end
                DATA: begin
                    i2c_sclk <= (phase == 2'd1) || (phase == 2'd2);
                    sda_low  <= ~shift_reg[31];
                end
                ACKS: begin
                    i2c_sclk <= (phase == 2'd1) || (phase == 2'd2);
                    sda_low  <= 1'b0;
                end
                STOP: begin
                    i2c_sclk <= (phase != 2'd0);
                    sda_low  <= (phase < 2'd2);
                end
                default: begin
                    i2c_sclk <= 1'b1;
                    sda_low  <= 1'b0;
                end
            endcase

            // Quarter-bit divider runs only while a frame is on the bus.
            if (state inside {START, DATA, ACKS, STOP}) begin
                if (tick) begin
                    div_cnt <= '0;
                    phase   <= phase + 2'd1;
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start && !tr_end) begin
                        shift_reg <= i2c_data;
                        div_cnt   <= '0;
                        phase     <= '0;
                        busy      <= 1'b1;
                        ack       <= 1'b0;
                        nack      <= 1'b0;
                        byte_cnt  <= 2'd0;
                        state     <= START;
                    end
                end
                START: begin
                    if (slot_end) begin
                        bit_cnt <= 3'd7;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (slot_end) begin
                        shift_reg <= {shift_reg[30:0], 1'b0};
                        if (bit_cnt == 3'd0) begin
                            state <= ACKS;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                        end
                    end
                end
                ACKS: begin
                    // Sample at the q1->q2 boundary, mid SCL-high.
                    if (tick && (phase == 2'd1)) begin
                        nack <= sda_p1;
                    end
                    if (slot_end) begin
                        if (nack) begin
                            state <= STOP;
                        end else if (byte_cnt == 2'd3) begin
                            ack   <= 1'b1;
                            state <= STOP;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                            bit_cnt  <= 3'd7;
                            state    <= DATA;
                        end
                    end
                end
                STOP: begin
                    if (slot_end) begin
                        busy   <= 1'b0;
                        tr_end <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // A held request never retriggers; wait for it to drop.
                    if (!start) begin
                        tr_end <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_write_master.sv
// tb_sccb_write_master
//   Drives SCCB write frames into sccb_write_master (CLK_DIV = 4), decodes
//   the SCL/SDA bus with a slave model that ACKs up to a chosen byte, and
//   compares decoded bytes, latency, ack status and handshake behaviour
//   with values computed from the frame contents.
module tb_sccb_write_master;

    localparam int CLK_DIV = 4;
    localparam int SLOT    = 4 * CLK_DIV;

    logic        clk_25M = 1'b0;
    logic        rst;
    logic [31:0] i2c_data;
    logic        start;
    logic        busy;
    logic        tr_end;
    logic        ack;
    logic        i2c_sclk;
    wire         sda;
    logic        slave_low = 1'b0;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    sccb_write_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk_25M (clk_25M),
        .rst     (rst),
        .i2c_data(i2c_data),
        .start   (start),
        .busy    (busy),
        .tr_end  (tr_end),
        .ack     (ack),
        .i2c_sclk(i2c_sclk),
        .i2c_sdat(sda)
    );

    always #20 clk_25M = ~clk_25M;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // bus monitor / slave state
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         scl_rises = 0;
    int         bit_idx   = 0;
    int         byte_idx  = 0;
    int         nack_byte = 4;
    logic [7:0] shreg     = 8'h00;
    logic [7:0] rx[$];

    initial forever begin
        @(posedge clk_25M);
        cyc++;
    end

    // Slave model: decode START/STOP/bits, ACK bytes below nack_byte.
    initial begin
        logic scl_prev, sda_prev, scl_now, sda_now;
        scl_prev = 1'b1;
        sda_prev = 1'b1;
        forever begin
            @(negedge clk_25M);
            scl_now = i2c_sclk;
            sda_now = sda;
            if (scl_now && scl_prev && sda_prev && !sda_now) begin
                start_cnt++;
                bit_idx  = 0;
                byte_idx = 0;
            end else if (scl_now && scl_prev && !sda_prev && sda_now) begin
                stop_cnt++;
            end
            if (scl_now && !scl_prev) begin
                scl_rises++;
                if (bit_idx < 8) begin
                    shreg = {shreg[6:0], sda_now};
                    bit_idx++;
                    if (bit_idx == 8) rx.push_back(shreg);
                end else begin
                    bit_idx++;
                end
            end
            if (!scl_now && scl_prev) begin
                if (bit_idx == 8) begin
                    slave_low = (byte_idx < nack_byte);
                end else if (bit_idx >= 9) begin
                    slave_low = 1'b0;
                    bit_idx   = 0;
                    byte_idx++;
                end
            end
            scl_prev = scl_now;
            sda_prev = sda_now;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete handshake; nack_at = byte index the slave leaves
    // unacknowledged (4 = ACK everything).
    task automatic run_frame(input logic [31:0] frame, input int nack_at,
                             input bit scramble, input int hold);
        int base_rx, base_start, base_stop, a_cyc, last, lat_exp, rises;
        logic [7:0] exp_b;
        nack_byte  = nack_at;
        base_rx    = rx.size();
        base_start = start_cnt;
        base_stop  = stop_cnt;
        last       = (nack_at > 3) ? 3 : nack_at;
        lat_exp    = (2 + 9 * (last + 1)) * SLOT;

        @(negedge clk_25M);
        i2c_data = frame;
        start    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_25M);
            if (busy) break;
        end
        check("busy_on_accept", {31'd0, busy}, 32'd1);
        check("tr_end_low_while_busy", {31'd0, tr_end}, 32'd0);
        a_cyc = cyc;

        for (int i = 0; i < 4000; i++) begin
            if (tr_end) break;
            @(negedge clk_25M);
            if (scramble && (cyc % 10 == 0)) i2c_data = $urandom;
        end
        check("tr_end_rise", {31'd0, tr_end}, 32'd1);
        check("latency", 32'(cyc - a_cyc), 32'(lat_exp));
        check("ack", {31'd0, ack}, {31'd0, (nack_at > 3)});
        check("busy_off_at_done", {31'd0, busy}, 32'd0);
        check("bytes_on_bus", 32'(rx.size() - base_rx), 32'(last + 1));
        for (int i = 0; i <= last; i++) begin
            exp_b = 8'(frame >> (24 - 8 * i));
            if (rx.size() > base_rx + i)
                check("bus_byte", {24'd0, rx[base_rx + i]}, {24'd0, exp_b});
        end
        check("start_conditions", 32'(start_cnt - base_start), 32'd1);
        check("stop_conditions", 32'(stop_cnt - base_stop), 32'd1);

        rises = scl_rises;
        repeat (hold) @(negedge clk_25M);
        check("no_scl_after_stop", 32'(scl_rises - rises), 32'd0);
        check("no_restart_while_held", 32'(start_cnt - base_start), 32'd1);
        check("tr_end_held", {31'd0, tr_end}, 32'd1);

        start = 1'b0;
        @(negedge clk_25M);
        check("tr_end_fall", {31'd0, tr_end}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        @(negedge clk_25M);
    endtask

    task automatic check_reset_lines(input string tag);
        check({tag, "_sclk"},   {31'd0, i2c_sclk}, 32'd1);
        check({tag, "_sda"},    {31'd0, sda},      32'd1);
        check({tag, "_busy"},   {31'd0, busy},     32'd0);
        check({tag, "_tr_end"}, {31'd0, tr_end},   32'd0);
        check({tag, "_ack"},    {31'd0, ack},      32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        i2c_data = 32'h0;
        @(negedge clk_25M);
        check_reset_lines("por");
        repeat (2) @(negedge clk_25M);
        rst = 1'b0;

        run_frame(32'h78310311, 4, 1'b0, 20);
        run_frame(32'h78310311, 0, 1'b0, 20);
        run_frame(32'h78123456, 4, 1'b0, 1000);
        run_frame(32'h78300882, 4, 1'b1, 20);

        for (int k = 0; k < 4; k++)
            run_frame({8'h78, 24'($urandom)}, int'($urandom_range(0, 4)), 1'b1, 10);

        // Reset during the third bit slot of byte 1.
        nack_byte = 4;
        @(negedge clk_25M);
        i2c_data = 32'h78AA55C3;
        start    = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_25M);
            if (byte_idx == 1 && bit_idx == 3) break;
        end
        check("reached_mid_byte1", 32'(bit_idx), 32'd3);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk_25M);
        check_reset_lines("mid_rst");
        repeat (2) @(negedge clk_25M);
        rst = 1'b0;
        run_frame({8'h78, 24'($urandom)}, 4, 1'b0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sccb_write_master.md
# sccb_write_master

Byte-level SCCB/I2C write engine for the OV5640 camera interface. It takes one 32-bit write frame (device address, 16-bit register address, data byte) from the register-table sequencer and serialises it onto the open-drain SCL/SDA pair. It reports completion and acknowledge status through a four-phase request/done handshake, so a sequencer on a slower derived clock can use it safely. The block runs entirely on the 25 MHz system clock; an internal divider sets the bus rate.

## Interface
- CLK_DIV, 312, system-clock cycles per quarter-bit phase. 312 gives SCL of about 20 kHz at 25 MHz. Legal range is 4 or more.
- clk_25M  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i2c_data  in  32  write frame: [31:24] device address (0x78, bit0 = 0 for write), [23:8] register address, [7:0] data.
- start  in  1  request level. Raise it to request a frame and hold it until tr_end = 1.
- busy  out  1  high from frame accept until the STOP condition completes.
- tr_end  out  1  done level. Set at end of frame; cleared the cycle after start is seen low.
- ack  out  1  1 = every transmitted byte was ACKed. Valid while tr_end = 1; holds its value until the next accept.
- i2c_sclk  out  1  SCL; driven high or low (push-pull).
- i2c_sdat  inout  1  SDA; open-drain. Drives 0 or is released to Z.

## Operation
- Reset values:
  - i2c_sclk = 1, SDA released.
  - busy = 0, tr_end = 0, ack = 0.
  - State IDLE, phase counter = 0.
- Input path: SDA input passes through a 2-flop synchroniser before use.
- Phase timing: a divider counts 0..CLK_DIV-1 and emits a tick on the terminal count. Each bit slot is 4 phases, q0..q3, and each phase lasts CLK_DIV cycles.
- States: IDLE, START, DATA, ACKS, STOP, DONE.
- IDLE:
  - If start = 1 and tr_end = 0, accept the frame: latch i2c_data into a 32-bit shift register, clear the divider, set busy = 1, clear ack, set byte count = 0, go to START.
  - i2c_data is ignored at all other times.
- START: q0 SDA=Z, SCL=1; q1 SDA=0, SCL=1; q2 SDA=0, SCL=0; q3 hold. Then go to DATA with bit count = 7.
- DATA, one slot per bit, MSB first:
  - q0 SCL=0, SDA = 0 if the bit is 0, otherwise Z.
  - q1 and q2 SCL=1.
  - q3 SCL=0.
  - After 8 slots, go to ACKS.
- ACKS:
  - SDA released.
  - SCL: q0=0, q1=1, q2=1, q3=0.
  - Synchronised SDA is sampled on entry to q2.
  - Sample 0 (ACK): if byte count < 3, increment it and go to DATA; if byte count = 3, set ack = 1 and go to STOP.
  - Sample 1 (NACK): ack stays 0; go to STOP immediately. Remaining bytes are not sent.
- STOP: q0 SCL=0, SDA=0; q1 SCL=1, SDA=0; q2 SCL=1, SDA=Z; q3 hold. Then go to DONE.
- DONE:
  - busy = 0, tr_end = 1.
  - Remain in DONE while start = 1.
  - When start = 0, clear tr_end on the next edge and go to IDLE.
  - Holding start high never retriggers a frame.
- Reset mid-frame: on the next edge SCL = 1, SDA is released, and all outputs return to reset values. No STOP is generated; the slave is resynchronised by the next START.

## Timing
- Frame accept: on the edge where IDLE sees start = 1. busy rises on that same edge, and START q0 begins on the next cycle.
- Full ACKed frame: 38 slots (1 START + 4×9 + 1 STOP) × 4 × CLK_DIV cycles from accept to tr_end rise. This is 47424 cycles at 312, or 608 at 4.
- NACK on byte n (n = 0..3): (1 + 9·(n+1) + 1) × 4 × CLK_DIV cycles.
- tr_end and busy change on the same edge; busy never overlaps tr_end.
- SDA only changes while SCL = 0, except during the START and STOP phases.
- Handshake:
  - The requester must not raise start while tr_end = 1.
  - Minimum gap between frames: 1 cycle in DONE after start falls, plus 1 cycle in IDLE.

## Test plan
- Reset: hold rst for 3 cycles during a frame. Next edge: i2c_sclk = 1, SDA = Z, busy = 0, tr_end = 0, ack = 0.
- Full write, CLK_DIV = 4, frame 0x78310311, slave model ACKs every byte:
  - Decoded bus bytes are 78, 31, 03, 11, then STOP.
  - tr_end rises 608 cycles after accept, with ack = 1.
- NACK on device address (slave silent):
  - STOP follows the first ACK slot.
  - tr_end rises after 176 cycles, with ack = 0.
  - No SCL pulses after the STOP.
- Handshake: keep start = 1 for 1000 cycles after tr_end.
  - No new START appears.
  - Drop start: tr_end falls 1 cycle later.
  - Raise start with frame 0x78300882: second frame accepted and decoded correctly.
- i2c_data stability: change i2c_data every 10 cycles during busy. The bus still carries the bytes latched at accept.
- Mid-byte reset: assert rst during the third DATA slot of byte 1. Lines are released next edge; a fresh frame afterwards completes with ack = 1.
